// File: rtl/pred_reg_pkg.sv
// Shared defaults and helpers for the CGRA PE predicate register bank.
package pred_reg_pkg;

    localparam int PW_DEF    = 4;
    localparam int DEPTH_DEF = 64;
    localparam int NCH_DEF   = 4;
    localparam int BUS_CH    = NCH_DEF - 1;

    // True when exactly one bit of v is set.
    function automatic logic onehot_ok(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/pred_reg_bank_if.sv
// Signal bundle between a PE datapath (master) and its predicate register bank (slave).
interface pred_reg_bank_if #(
    parameter int PW  = 4,
    parameter int AW  = 6,
    parameter int NCH = 4
);

    logic [NCH*PW-1:0] ch_p_in;
    logic [NCH-1:0]    in_sel;
    logic [AW-1:0]     put_in_addr;
    logic              write_back_p;
    logic [PW-1:0]     out2pred;
    logic [AW-1:0]     put_out_addr;
    logic [NCH-1:0]    fu_sel;
    logic [AW-1:0]     pred_addr;
    logic [PW-1:0]     pred_out;
    logic              pred_vld;
    logic              send_en;
    logic [AW-1:0]     send_addr;
    logic [NCH-1:0]    out_en;
    logic [NCH*PW-1:0] ch_p_out;
    logic [NCH-1:0]    ch_vld_out;
    logic              clear_all;
    logic [AW:0]       occupancy;
    logic              sel_err;

    modport master (
        output ch_p_in, in_sel, put_in_addr, write_back_p, out2pred, put_out_addr,
               fu_sel, pred_addr, send_en, send_addr, out_en, clear_all,
        input  pred_out, pred_vld, ch_p_out, ch_vld_out, occupancy, sel_err
    );

    modport slave (
        input  ch_p_in, in_sel, put_in_addr, write_back_p, out2pred, put_out_addr,
               fu_sel, pred_addr, send_en, send_addr, out_en, clear_all,
        output pred_out, pred_vld, ch_p_out, ch_vld_out, occupancy, sel_err
    );

endinterface

// File: rtl/pred_chan_mux.sv
// One-hot channel slice selector; flags a multi-hot select instead of OR-ing slices together.
module pred_chan_mux
    import pred_reg_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int PW  = PW_DEF
) (
    input  logic [NCH-1:0]    sel,
    input  logic [NCH*PW-1:0] ch,
    output logic [PW-1:0]     data,
    output logic              hit,
    output logic              err
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        data = '0;
        hit  = onehot_ok(32'(sel));
        err  = (|sel) && !hit;
        for (int c = 0; c < NCH; c++) begin
            if (hit && sel[c]) data = ch[c*PW +: PW];
        end
    end

endmodule

// File: rtl/pred_reg_bank.sv
// Predicate register bank: channel capture, FU write-back, FU operand read and registered channel send.
module pred_reg_bank
    import pred_reg_pkg::*;
#(
    parameter int PW      = PW_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int AW      = $clog2(DEPTH),
    parameter int NCH     = NCH_DEF,
    parameter int CONSUME = 0
) (
    input  logic           CLK,
    input  logic           RST_N,
    pred_reg_bank_if.slave bus
);

    logic [PW-1:0]     mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  valid_nxt;
    logic [AW:0]       occ_q;
    logic [AW:0]       occ_nxt;
    logic [NCH*PW-1:0] ch_p_out_q;
    logic [NCH-1:0]    ch_vld_q;
    logic              sel_err_q;

    logic [PW-1:0] cap_data, fu_data, send_data;
    logic          cap_hit, cap_err, fu_hit, fu_err;
    logic          cap_we, wb_we, send_ok, send_vld, consume_clr;
    logic          inc_cap, inc_wb, dec_consume;
    logic          rd_ok;

    // Non-power-of-2 depths leave a hole at the top of the address space.
    function automatic logic in_range(input logic [AW-1:0] a);
        return (AW+1)'(a) < (AW+1)'(DEPTH);
    endfunction

    pred_chan_mux #(.NCH(NCH), .PW(PW)) u_cap_mux (
        .sel  (bus.in_sel),
        .ch   (bus.ch_p_in),
        .data (cap_data),
        .hit  (cap_hit),
        .err  (cap_err)
    );

    pred_chan_mux #(.NCH(NCH), .PW(PW)) u_fu_mux (
        .sel  (bus.fu_sel),
        .ch   (bus.ch_p_in),
        .data (fu_data),
        .hit  (fu_hit),
        .err  (fu_err)
    );

    always_comb begin
        cap_we      = cap_hit && in_range(bus.put_in_addr);
        wb_we       = bus.write_back_p && in_range(bus.put_out_addr);
        send_ok     = bus.send_en && in_range(bus.send_addr);
        send_data   = send_ok ? mem[bus.send_addr] : '0;
        send_vld    = send_ok && valid[bus.send_addr];
        consume_clr = (CONSUME != 0) && send_vld;

        // A write to the sent address re-validates it, so it beats the consume clear.
        valid_nxt = valid;
        if (consume_clr) valid_nxt[bus.send_addr] = 1'b0;
        if (cap_we)      valid_nxt[bus.put_in_addr] = 1'b1;
        if (wb_we)       valid_nxt[bus.put_out_addr] = 1'b1;
        if (bus.clear_all) valid_nxt = '0;

        // Same-address capture and write-back is one write, so count it once.
        inc_cap     = cap_we && !valid[bus.put_in_addr];
        inc_wb      = wb_we && !valid[bus.put_out_addr]
                      && !(cap_we && (bus.put_in_addr == bus.put_out_addr));
        dec_consume = consume_clr
                      && !(cap_we && (bus.put_in_addr == bus.send_addr))
                      && !(wb_we && (bus.put_out_addr == bus.send_addr));
        occ_nxt = bus.clear_all ? '0
                : occ_q + (AW+1)'(inc_cap) + (AW+1)'(inc_wb) - (AW+1)'(dec_consume);
    end

    // NOTE: the bank updates on the falling clock edge so the FU sees a settled operand on the rising edge.
    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the data array is reset too, so it must be flops rather than an inferred RAM.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            valid      <= '0;
            occ_q      <= '0;
            ch_p_out_q <= '0;
            ch_vld_q   <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking writes make write-back (second) win a same-address capture.
            if (cap_we) mem[bus.put_in_addr] <= cap_data;
            if (wb_we)  mem[bus.put_out_addr] <= bus.out2pred;
            valid <= valid_nxt;
            occ_q <= occ_nxt;
            for (int c = 0; c < NCH; c++) begin
                ch_p_out_q[c*PW +: PW] <= bus.out_en[c] ? send_data : '0;
                ch_vld_q[c]            <= bus.out_en[c] && send_vld;
            end
            sel_err_q <= cap_err || fu_err;
        end
    end

    always_comb begin
        rd_ok        = in_range(bus.pred_addr);
        bus.pred_out = '0;
        bus.pred_vld = 1'b0;
        if (fu_hit) begin
            bus.pred_out = fu_data;
            bus.pred_vld = 1'b1;
        end else if (!fu_err && rd_ok) begin
            bus.pred_out = mem[bus.pred_addr];
            bus.pred_vld = valid[bus.pred_addr];
        end
    end

    assign bus.ch_p_out   = ch_p_out_q;
    assign bus.ch_vld_out = ch_vld_q;
    assign bus.occupancy  = occ_q;
    assign bus.sel_err    = sel_err_q;

endmodule

// File: tb/tb_pred_reg_bank.sv
// Random plus directed bench for pred_reg_bank, comparing a plain-consume and a consume-on-send bank to a reference model.
module tb_pred_reg_bank;
    import pred_reg_pkg::*;

    localparam int PW    = 4;
    localparam int DEPTH = 48;
    localparam int AW    = 6;
    localparam int NCH   = 4;

    logic CLK, RST_N;
    logic [NCH*PW-1:0] ch_p_in;
    logic [NCH-1:0]    in_sel, fu_sel, out_en;
    logic [AW-1:0]     put_in_addr, put_out_addr, pred_addr, send_addr;
    logic              write_back_p, send_en, clear_all;
    logic [PW-1:0]     out2pred;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state, index 0 = CONSUME 0, index 1 = CONSUME 1.
    logic [PW-1:0]     m_mem [2][DEPTH];
    logic              m_vld [2][DEPTH];
    logic [NCH*PW-1:0] e_ch_out [2];
    logic [NCH-1:0]    e_ch_vld [2];
    logic              e_sel_err;

    pred_reg_bank_if #(.PW(PW), .AW(AW), .NCH(NCH)) if0 ();
    pred_reg_bank_if #(.PW(PW), .AW(AW), .NCH(NCH)) if1 ();

    pred_reg_bank #(.PW(PW), .DEPTH(DEPTH), .AW(AW), .NCH(NCH), .CONSUME(0))
        dut0 (.CLK(CLK), .RST_N(RST_N), .bus(if0));
    pred_reg_bank #(.PW(PW), .DEPTH(DEPTH), .AW(AW), .NCH(NCH), .CONSUME(1))
        dut1 (.CLK(CLK), .RST_N(RST_N), .bus(if1));

    assign if0.ch_p_in = ch_p_in;           assign if1.ch_p_in = ch_p_in;
    assign if0.in_sel = in_sel;             assign if1.in_sel = in_sel;
    assign if0.put_in_addr = put_in_addr;   assign if1.put_in_addr = put_in_addr;
    assign if0.write_back_p = write_back_p; assign if1.write_back_p = write_back_p;
    assign if0.out2pred = out2pred;         assign if1.out2pred = out2pred;
    assign if0.put_out_addr = put_out_addr; assign if1.put_out_addr = put_out_addr;
    assign if0.fu_sel = fu_sel;             assign if1.fu_sel = fu_sel;
    assign if0.pred_addr = pred_addr;       assign if1.pred_addr = pred_addr;
    assign if0.send_en = send_en;           assign if1.send_en = send_en;
    assign if0.send_addr = send_addr;       assign if1.send_addr = send_addr;
    assign if0.out_en = out_en;             assign if1.out_en = out_en;
    assign if0.clear_all = clear_all;       assign if1.clear_all = clear_all;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        ch_p_in = '0; in_sel = '0; put_in_addr = '0; write_back_p = 1'b0;
        out2pred = '0; put_out_addr = '0; fu_sel = '0; pred_addr = '0;
        send_en = 1'b0; send_addr = '0; out_en = '0; clear_all = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[k][i] = '0;
                m_vld[k][i] = 1'b0;
            end
            e_ch_out[k] = '0;
            e_ch_vld[k] = '0;
        end
        e_sel_err = 1'b0;
    endtask

    function automatic int count_valid(input int k);
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_vld[k][i]);
        return n;
    endfunction

    function automatic int sel_index(input logic [NCH-1:0] s);
        for (int c = 0; c < NCH; c++) if (s[c]) return c;
        return 0;
    endfunction

    // Apply one falling edge's worth of bank rules to the model.
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            bit sa_ok = send_en && (int'(send_addr) < DEPTH);
            logic [PW-1:0] sd = '0;
            logic sv = 1'b0;
            if (sa_ok) begin
                sd = m_mem[k][send_addr];
                sv = m_vld[k][send_addr];
            end
            for (int c = 0; c < NCH; c++) begin
                e_ch_out[k][c*PW +: PW] = out_en[c] ? sd : '0;
                e_ch_vld[k][c]          = out_en[c] && sv;
            end
            if (k == 1 && sv) m_vld[k][send_addr] = 1'b0;
            if ($countones(in_sel) == 1 && int'(put_in_addr) < DEPTH) begin
                m_mem[k][put_in_addr] = ch_p_in[sel_index(in_sel)*PW +: PW];
                m_vld[k][put_in_addr] = 1'b1;
            end
            if (write_back_p && int'(put_out_addr) < DEPTH) begin
                m_mem[k][put_out_addr] = out2pred;
                m_vld[k][put_out_addr] = 1'b1;
            end
            if (clear_all) for (int i = 0; i < DEPTH; i++) m_vld[k][i] = 1'b0;
        end
        e_sel_err = ($countones(in_sel) > 1) || ($countones(fu_sel) > 1);
    endtask

    task automatic check_operand();
        for (int k = 0; k < 2; k++) begin
            logic [PW-1:0] ep = '0;
            logic ev = 1'b0;
            if ($countones(fu_sel) == 1) begin
                ep = ch_p_in[sel_index(fu_sel)*PW +: PW];
                ev = 1'b1;
            end else if (fu_sel == '0 && int'(pred_addr) < DEPTH) begin
                ep = m_mem[k][pred_addr];
                ev = m_vld[k][pred_addr];
            end
            check($sformatf("pred_out%0d", k), 32'(k == 0 ? if0.pred_out : if1.pred_out), 32'(ep));
            check($sformatf("pred_vld%0d", k), 32'(k == 0 ? if0.pred_vld : if1.pred_vld), 32'(ev));
        end
    endtask

    task automatic check_regs();
        check("occ0", 32'(if0.occupancy), 32'(count_valid(0)));
        check("occ1", 32'(if1.occupancy), 32'(count_valid(1)));
        check("ch_out0", 32'(if0.ch_p_out), 32'(e_ch_out[0]));
        check("ch_out1", 32'(if1.ch_p_out), 32'(e_ch_out[1]));
        check("ch_vld0", 32'(if0.ch_vld_out), 32'(e_ch_vld[0]));
        check("ch_vld1", 32'(if1.ch_vld_out), 32'(e_ch_vld[1]));
        check("sel_err0", 32'(if0.sel_err), 32'(e_sel_err));
        check("sel_err1", 32'(if1.sel_err), 32'(e_sel_err));
    endtask

    // Inputs are set just after a rising edge; one call covers one falling edge.
    task automatic step();
        #1;
        check_operand();
        @(negedge CLK);
        model_update();
        #1;
        check_regs();
        @(posedge CLK);
    endtask

    function automatic logic [NCH-1:0] rand_sel();
        int r = $urandom_range(0, 9);
        if (r < NCH) return NCH'(1 << r);
        if (r < 6) return '0;
        return NCH'($urandom);
    endfunction

    initial begin
        idle();
        model_reset();
        RST_N = 1'b1;
        #2 RST_N = 1'b0;
        #1;
        check("rst_occ", 32'(if0.occupancy), 32'd0);
        check("rst_ch_out", 32'(if1.ch_p_out), 32'd0);
        check("rst_ch_vld", 32'(if0.ch_vld_out), 32'd0);
        check("rst_sel_err", 32'(if1.sel_err), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        RST_N = 1'b1;

        // Capture A from channel 0 into address 5, then read it back.
        in_sel = 4'b0001; ch_p_in = 16'h000A; put_in_addr = 6'd5;
        step();
        idle(); pred_addr = 6'd5;
        step();
        check("t1_pred", 32'(if0.pred_out), 32'hA);
        check("t1_occ", 32'(if0.occupancy), 32'd1);

        // Capture from the bus channel and write-back to the same address.
        in_sel = 4'(1 << BUS_CH); ch_p_in = 16'h3000; put_in_addr = 6'd9;
        write_back_p = 1'b1; out2pred = 4'h7; put_out_addr = 6'd9;
        step();
        idle(); pred_addr = 6'd9;
        step();
        check("t2_pred", 32'(if0.pred_out), 32'h7);
        check("t2_occ", 32'(if0.occupancy), 32'd2);

        // Broadcast send of address 2 to channels 0 and 2.
        write_back_p = 1'b1; out2pred = 4'hC; put_out_addr = 6'd2;
        step();
        idle(); send_en = 1'b1; send_addr = 6'd2; out_en = 4'b0101;
        step();
        check("t3_ch_out", 32'(if0.ch_p_out), 32'h0C0C);
        check("t3_consumed", 32'(if1.occupancy), 32'd2);

        // Consume overridden by a same-cycle write-back to the sent address.
        idle(); write_back_p = 1'b1; out2pred = 4'h5; put_out_addr = 6'd2;
        step();
        idle(); send_en = 1'b1; send_addr = 6'd2; out_en = 4'b0001;
        write_back_p = 1'b1; out2pred = 4'h6; put_out_addr = 6'd2;
        step();
        idle(); pred_addr = 6'd2;
        step();
        check("t4_keep", 32'(if1.pred_vld), 32'd1);

        // Multi-hot selects, then an out-of-range write and read.
        idle(); in_sel = 4'b0011; ch_p_in = 16'hFFFF; put_in_addr = 6'd20;
        step();
        check("t5_sel_err", 32'(if0.sel_err), 32'd1);
        idle(); fu_sel = 4'b0110; ch_p_in = 16'h1234;
        step();
        idle(); write_back_p = 1'b1; out2pred = 4'hF; put_out_addr = 6'd50; pred_addr = 6'd50;
        step();
        idle();
        step();
        check("t5_err_drop", 32'(if0.sel_err), 32'd0);

        // Fill every entry, then clear together with a write.
        for (int a = 0; a < DEPTH; a++) begin
            idle(); write_back_p = 1'b1; out2pred = PW'($urandom); put_out_addr = AW'(a);
            step();
        end
        check("t6_full", 32'(if0.occupancy), 32'(DEPTH));
        idle(); clear_all = 1'b1; in_sel = 4'b0100; ch_p_in = 16'h0900; put_in_addr = 6'd3;
        step();
        check("t6_clear", 32'(if1.occupancy), 32'd0);

        for (int n = 0; n < 400; n++) begin
            ch_p_in = 16'($urandom);
            in_sel = rand_sel(); fu_sel = rand_sel();
            put_in_addr = AW'($urandom); put_out_addr = AW'($urandom);
            pred_addr = AW'($urandom); send_addr = AW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                put_out_addr = send_addr;
                put_in_addr = pred_addr;
            end
            write_back_p = 1'($urandom); out2pred = PW'($urandom);
            send_en = 1'($urandom); out_en = NCH'($urandom);
            clear_all = ($urandom_range(0, 40) == 0);
            step();
        end

        // Reset asserted while a send is on the outputs.
        idle(); write_back_p = 1'b1; out2pred = 4'h9; put_out_addr = 6'd4;
        step();
        idle(); send_en = 1'b1; send_addr = 6'd4; out_en = 4'b1111;
        step();
        check("t6_send", 32'(if0.ch_vld_out), 32'hF);
        #2 RST_N = 1'b0;
        model_reset();
        #1;
        check("t6_rst_out", 32'(if0.ch_p_out), 32'd0);
        check("t6_rst_vld", 32'(if1.ch_vld_out), 32'd0);
        check("t6_rst_occ", 32'(if0.occupancy), 32'd0);
        @(posedge CLK);
        RST_N = 1'b1;
        idle(); pred_addr = 6'd4;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
